// File: rtl/vect_stream_loader.sv
// Streams NWI passes over a packed-array memory through a 4-entry FIFO; first word valid 3 cycles after start.
// Reads are credit-limited to FIFO space, so m_tready low stalls reads and holds the FIFO head stable.
module vect_stream_loader #(
    parameter  int DATAW   = 32,
    parameter  int GVECT   = 2,
    parameter  int NINPUTS = 2,
    parameter  int SIZE    = 1024,
    parameter  int NWI     = 4,
    localparam int NWORDS  = SIZE / GVECT,
    localparam int ADDRW   = $clog2(NWORDS),
    localparam int WORDW   = DATAW * GVECT * NINPUTS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             mem_ren,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [WORDW-1:0] mem_rdata,
    output logic             m_tvalid,
    output logic [WORDW-1:0] m_tdata,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [31:0]      wi_count
);
    localparam int WIW = (NWI > 1) ? $clog2(NWI) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           r_state;
    logic             r_busy;
    logic [ADDRW-1:0] r_nxt_addr;
    logic [WIW-1:0]   r_nxt_wi;
    logic             r_mem_ren;
    logic [ADDRW-1:0] r_mem_raddr;
    logic             r_mem_last;
    logic             r_rd_vld;
    logic             r_rd_last;
    logic [WORDW-1:0] r_fifo_dat [4];
    logic             r_fifo_last [4];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_count;
    logic [31:0]      r_wi_count;

    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_commit;
    logic             w_start_ok;
    logic             w_issue;
    logic [ADDRW-1:0] w_iss_addr;
    logic [WIW-1:0]   w_iss_wi;
    logic             w_iss_last_word;
    logic             w_iss_final;
    logic             w_done;

    assign w_push = r_rd_vld;
    assign w_pop  = (r_count != 3'd0) && m_tready;

    // Words already owed to the FIFO after this edge: stored, on the bus, or requested last cycle.
    assign w_commit = 4'(r_count) + 4'(r_rd_vld) + 4'(r_mem_ren) - 4'(w_pop);

    assign w_start_ok      = (r_state == IDLE) && start;
    assign w_issue         = w_start_ok || ((r_state == RUN) && (w_commit < 4'd4));
    assign w_iss_addr      = w_start_ok ? '0 : r_nxt_addr;
    assign w_iss_wi        = w_start_ok ? '0 : r_nxt_wi;
    assign w_iss_last_word = (w_iss_addr == ADDRW'(NWORDS - 1));
    assign w_iss_final     = w_iss_last_word && (w_iss_wi == WIW'(NWI - 1));

    // Final word: no more reads are outstanding and the last stored entry is leaving.
    assign w_done = (r_state == DRAIN) && w_pop && (r_count == 3'd1) && !r_rd_vld && !r_mem_ren;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_nxt_addr  <= '0;
            r_nxt_wi    <= '0;
            r_mem_ren   <= 1'b0;
            r_mem_raddr <= '0;
            r_mem_last  <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wi_count  <= '0;
        end else begin
            r_mem_ren <= w_issue;
            if (w_issue) begin
                r_mem_raddr <= w_iss_addr;
                r_mem_last  <= w_iss_last_word;
                r_nxt_addr  <= w_iss_last_word ? '0 : w_iss_addr + 1'b1;
                r_nxt_wi    <= w_iss_last_word ? w_iss_wi + 1'b1 : w_iss_wi;
            end
            r_rd_vld  <= r_mem_ren;
            r_rd_last <= r_mem_last;

            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + 3'(w_push) - 3'(w_pop);

            if (w_start_ok)
                r_wi_count <= '0;
            else if (w_pop && r_fifo_last[r_rd_ptr])
                r_wi_count <= r_wi_count + 32'd1;

            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state <= w_iss_final ? DRAIN : RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_issue && w_iss_final) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Payload storage needs no reset; occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_dat[r_wr_ptr]  <= mem_rdata;
            r_fifo_last[r_wr_ptr] <= r_rd_last;
        end
    end

    assign busy      = r_busy;
    assign done      = w_done;
    assign mem_ren   = r_mem_ren;
    assign mem_raddr = r_mem_raddr;
    assign m_tvalid  = (r_count != 3'd0);
    assign m_tdata   = r_fifo_dat[r_rd_ptr];
    assign m_tlast   = m_tvalid && r_fifo_last[r_rd_ptr];
    assign wi_count  = r_wi_count;

endmodule

// File: tb/tb_vect_stream_loader.sv
// Directed bench for vect_stream_loader: ordered word stream, credit limit, stalls, reset and restart.
module tb_vect_stream_loader;
    localparam int NWORDS = 512;
    localparam int NWI    = 4;
    localparam int TOTAL  = NWORDS * NWI;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         m_tready = 1'b1;
    logic         busy, done, mem_ren, m_tvalid, m_tlast;
    logic [8:0]   mem_raddr;
    logic [127:0] mem_rdata = '0;
    logic [127:0] m_tdata;
    logic [31:0]  wi_count;

    int n_checks = 0;
    int n_errors = 0;

    vect_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tready(m_tready), .wi_count(wi_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word k: every lane holds k+1 in its low 24 bits, lane number in its top byte.
    function automatic logic [127:0] word_of(input int k);
        logic [127:0] w;
        logic [23:0]  v;
        v = 24'(k + 1);
        for (int j = 0; j < 4; j++) w[32*j +: 32] = {8'(j), v};
        return w;
    endfunction

    always @(posedge clk) if (mem_ren) mem_rdata <= word_of(int'(mem_raddr));

    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 9) >= 3);
                default: m_tready = 1'b0;
            endcase
        end
    end

    int           exp_idx = 0;
    int           done_cnt = 0;
    int           mdl_cnt = 0;
    int           mdl_rdv = 0;
    bit           nobub = 0;
    bit           seen_vld = 0;
    bit           prev_stall = 0;
    bit           mon_hs;
    logic [127:0] prev_dat;
    logic         prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_cnt    = 0;
            mdl_rdv    = 0;
            prev_stall = 0;
        end else begin
            mon_hs = m_tvalid && m_tready;
            check_val("valid_vs_occupancy", m_tvalid, mdl_cnt != 0);
            if (mem_ren) check_val("read_credit", (mdl_cnt + mdl_rdv) < 4, 1'b1);
            if (prev_stall) begin
                check_val("stall_data", m_tdata, prev_dat);
                check_val("stall_last", m_tlast, prev_last);
            end
            if (nobub && seen_vld && exp_idx < TOTAL) check_val("bubble", m_tvalid, 1'b1);
            if (m_tvalid) seen_vld = 1;
            if (mon_hs) begin
                check_val("data", m_tdata, word_of(exp_idx % NWORDS));
                check_val("last", m_tlast, (exp_idx % NWORDS) == NWORDS - 1);
                check_val("wi_count", wi_count, exp_idx / NWORDS);
                check_val("done_at_hs", done, exp_idx == TOTAL - 1);
                exp_idx++;
            end else if (done) begin
                check_val("done_without_hs", done, 1'b0);
            end
            if (done) done_cnt++;
            prev_stall = m_tvalid && !m_tready;
            prev_dat   = m_tdata;
            prev_last  = m_tlast;
            mdl_cnt    = mdl_cnt + mdl_rdv - (mon_hs ? 1 : 0);
            mdl_rdv    = mem_ren ? 1 : 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_done"}, done, 1'b0);
        check_val({tag, "_mem_ren"}, mem_ren, 1'b0);
        check_val({tag, "_mem_raddr"}, mem_raddr, 9'd0);
        check_val({tag, "_tvalid"}, m_tvalid, 1'b0);
        check_val({tag, "_tlast"}, m_tlast, 1'b0);
        check_val({tag, "_wi_count"}, wi_count, 32'd0);
    endtask

    task automatic prep(input bit nb);
        exp_idx  = 0;
        done_cnt = 0;
        seen_vld = 0;
        nobub    = nb;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("lat_n1_mem_ren", mem_ren, 1'b1);
        check_val("lat_n1_raddr", mem_raddr, 9'd0);
        check_val("lat_n1_busy", busy, 1'b1);
        check_val("start_clears_wi", wi_count, 32'd0);
        check_val("lat_n1_tvalid", m_tvalid, 1'b0);
        @(negedge clk);
        check_val("lat_n2_tvalid", m_tvalid, 1'b0);
        @(negedge clk);
        check_val("lat_n3_tvalid", m_tvalid, 1'b1);
    endtask

    task automatic wait_idle(input int pulse_at);
        int c;
        c = 0;
        while (busy && c < 8000) begin
            @(negedge clk);
            c++;
            start = (c == pulse_at);
        end
        start = 1'b0;
        check_val("run_timeout", busy, 1'b0);
        @(negedge clk);
        check_val("end_words", exp_idx, TOTAL);
        check_val("end_done_pulses", done_cnt, 1);
        check_val("end_wi_count", wi_count, NWI);
        check_val("end_busy", busy, 1'b0);
        check_val("end_mem_ren", mem_ren, 1'b0);
        check_val("end_tvalid", m_tvalid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Full run, ready always high.
        rdy_mode = 0;
        prep(1);
        do_start();
        wait_idle(-1);

        // Random 30% backpressure.
        rdy_mode = 1;
        prep(0);
        do_start();
        wait_idle(-1);

        // Hold ready low 20 cycles: FIFO fills, reads stop.
        rdy_mode = 2;
        prep(1);
        do_start();
        repeat (17) @(negedge clk);
        check_val("fill_mem_ren", mem_ren, 1'b0);
        check_val("fill_occupancy", mdl_cnt, 4);
        check_val("fill_tvalid", m_tvalid, 1'b1);
        check_val("fill_head", m_tdata, word_of(0));
        rdy_mode = 0;
        wait_idle(-1);

        // One-cycle reset around word 100, then a clean restart.
        rdy_mode = 0;
        prep(1);
        do_start();
        begin
            int c;
            c = 0;
            while (exp_idx < 100 && c < 500) begin
                @(negedge clk);
                c++;
            end
            check_val("reach_word_100", exp_idx >= 100, 1'b1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_run_reset");
        prep(1);
        do_start();
        wait_idle(-1);

        // Start pulsed while busy must be ignored.
        prep(1);
        do_start();
        wait_idle(300);
        prep(1);
        do_start();
        wait_idle(2040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
